// File: rtl/mem_master_pkg.sv
// Shared definitions for the mem_master block: default sizes, FSM state
// encodings and request-source codes.
`timescale 1ns/1ps
package mem_master_pkg;

    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_MEM_DEPTH = 1000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        SRC_FETCH = 1'b0,
        SRC_LS    = 1'b1
    } src_t;

endpackage

// File: rtl/mem_rr_arb.sv
// Two-requester alternating-priority arbiter. On a tie the source that did not
// win last time is granted; last_grant resets to FETCH so the first tie goes to LS.
`timescale 1ns/1ps
module mem_rr_arb
    import mem_master_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_req_fetch,
    input  logic i_req_ls,
    output logic o_gnt_fetch,
    output logic o_gnt_ls
);

    src_t r_last;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_gnt_fetch = 1'b0;
        o_gnt_ls    = 1'b0;
        if (i_en) begin
            if (i_req_fetch && i_req_ls) begin
                o_gnt_ls    = (r_last == SRC_FETCH);
                o_gnt_fetch = (r_last == SRC_LS);
            end else begin
                o_gnt_fetch = i_req_fetch;
                o_gnt_ls    = i_req_ls;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= SRC_FETCH;
        end else if (o_gnt_fetch) begin
            r_last <= SRC_FETCH;
        end else if (o_gnt_ls) begin
            r_last <= SRC_LS;
        end
    end

endmodule

// File: rtl/mem_master.sv
// CPU-side memory initiator: arbitrates fetch and load/store requests and runs
// IDLE -> ACCESS -> RESP per access. Optional macro: MEM_BOUNDS_CHECK_EN.
`timescale 1ns/1ps
module mem_master
    import mem_master_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_data,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ready,
    output logic              ls_valid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_fault,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write_en,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    src_t              r_src;
    logic [DATA_W-1:0] r_if_data, r_ls_rdata;
    logic              w_gnt_fetch, w_gnt_ls, w_oob;

    if (MEM_DEPTH < 1 || MEM_DEPTH > (1 << ADDR_W)) begin : g_depth_check
        $error("mem_master: MEM_DEPTH must fit in the address space");
    end

    mem_rr_arb u_arb (
        .clk         (clk),
        .rst         (rst),
        .i_en        (r_state == IDLE),
        .i_req_fetch (if_req),
        .i_req_ls    (ls_req),
        .o_gnt_fetch (w_gnt_fetch),
        .o_gnt_ls    (w_gnt_ls)
    );

`ifdef MEM_BOUNDS_CHECK_EN
    localparam logic [ADDR_W-1:0] LP_DEPTH = ADDR_W'(MEM_DEPTH);
    logic r_fault;

    assign w_oob    = (r_addr >= LP_DEPTH);
    assign ls_fault = (r_state == RESP) && r_fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (r_state == ACCESS) begin
            r_fault <= w_oob;
        end
    end
`else
    assign w_oob    = 1'b0;
    assign ls_fault = 1'b0;
`endif

    always_comb begin
        w_next       = r_state;
        mem_address  = '0;
        mem_data_in  = '0;
        mem_write_en = 1'b0;
        case (r_state)
            IDLE:   if (w_gnt_fetch || w_gnt_ls) w_next = ACCESS;
            ACCESS: begin
                w_next       = RESP;
                mem_address  = r_addr;
                mem_data_in  = r_wdata;
                mem_write_en = r_we && !w_oob;
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request capture on grant; read data captured at the close of ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_src      <= SRC_FETCH;
            r_if_data  <= '0;
            r_ls_rdata <= '0;
        end else if (r_state == IDLE && (w_gnt_fetch || w_gnt_ls)) begin
            r_addr  <= w_gnt_fetch ? if_addr : ls_addr;
            r_we    <= w_gnt_ls && ls_we;
            r_wdata <= (w_gnt_ls && ls_we) ? ls_wdata : '0;
            r_src   <= w_gnt_fetch ? SRC_FETCH : SRC_LS;
        end else if (r_state == ACCESS && !r_we) begin
            if (r_src == SRC_FETCH) begin
                r_if_data <= w_oob ? '0 : mem_data_out;
            end else begin
                r_ls_rdata <= w_oob ? '0 : mem_data_out;
            end
        end
    end

    assign if_ready = w_gnt_fetch;
    assign ls_ready = w_gnt_ls;
    assign if_valid = (r_state == RESP) && (r_src == SRC_FETCH);
    assign ls_valid = (r_state == RESP) && (r_src == SRC_LS);
    assign if_data  = r_if_data;
    assign ls_rdata = r_ls_rdata;
    assign busy     = (r_state != IDLE);

endmodule
